controlador_barrido_display: RTL and testbench
==============================================

CONTROLADOR_BARRIDO_DISPLAY -- requirements
Module: controlador_barrido_display

Interface
REQ-001 SHALL have parameter CICLOS_DIGITO, default 32768; number of cycles each digit is lit (legal range >=1).
REQ-002 SHALL have parameter CICLOS_BLANCO, default 1024; number of all-off cycles before each digit (legal range >=0; 0 skips the blank phase).
REQ-003 reloj  in  1  sole clock; all flops on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 valor_valido  in  1  producer offers valor_bcd.
REQ-006 valor_listo  out  1  block can accept a value.
REQ-007 valor_bcd  in  12  [11:8]=centenas, [7:4]=decenas, [3:0]=unidades.
REQ-008 supr_ceros  in  1  leading-zero suppression request, sampled together with valor_bcd.
REQ-009 segmentos_out  out  7  segments abcdefg, a=bit6, active-high.
REQ-010 anodos_out  out  3  digit enables, active-low; 110=unidades, 101=decenas, 011=centenas.
REQ-011 fin_trama  out  1  one-cycle frame-end pulse.

Function
REQ-012 FSM states SHALL be BLANCO and MOSTRAR, plus a digit index 0..2 (0=unidades, 1=decenas, 2=centenas) and a phase cycle counter.
REQ-013 BLANCO SHALL last CICLOS_BLANCO cycles, then go to MOSTRAR with the counter cleared; if CICLOS_BLANCO=0, BLANCO is never entered.
REQ-014 MOSTRAR SHALL last CICLOS_DIGITO cycles, then advance the index (2 wraps to 0) and enter BLANCO (or MOSTRAR if CICLOS_BLANCO=0).
REQ-015 Frame period SHALL be exactly 3*(CICLOS_BLANCO+CICLOS_DIGITO) cycles.
REQ-016 In BLANCO, anodos_out SHALL be 111 and segmentos_out 0000000.
REQ-017 In MOSTRAR, anodos_out SHALL select the indexed digit, and segmentos_out SHALL be the decoded active-register digit.
REQ-018 Decoding: 0..9 map to 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011; any code >9 gives 0000000 with the anode still asserted.
REQ-019 Both outputs SHALL be combinational only from registered state (FSM, index, active register); no input-to-output path.
REQ-020 Holding register: valor_listo = NOT pendiente; valor_valido AND valor_listo at a posedge SHALL capture valor_bcd and supr_ceros and set pendiente.
REQ-021 fin_trama SHALL be high during the last MOSTRAR cycle of index 2.
REQ-022 On that same edge, if pendiente=1, the holding register SHALL copy into the active register and pendiente SHALL clear; if pendiente=0, the active register is unchanged. The display never changes mid-frame.
REQ-023 Capture and frame end in the same cycle are possible only with pendiente=0; the captured value SHALL stay pending until the next frame end.
REQ-024 Suppression (active supr=1): centenas=0 SHALL blank the centenas phase (anodos 111, segmentos 0000000); centenas=0 AND decenas=0 SHALL also blank decenas; unidades are never blanked.
REQ-025 Phase timing SHALL be unaffected by blanking or invalid digits.

Reset
REQ-026 reset=1 SHALL give: state BLANCO (MOSTRAR if CICLOS_BLANCO=0), index 0, counter 0, pendiente 0, active value 000 with supr 0, holding register 000.
REQ-027 Outputs during and in the cycle after reset: anodos_out 111 (or 110 if CICLOS_BLANCO=0), segmentos_out 0000000 (or 1111110), valor_listo 1, fin_trama 0.
REQ-028 Reset mid-operation SHALL discard any pending value and restart the frame at index 0.

Structure
REQ-029 Shared package SHALL hold: the state enum, anode codes (AN_UNI, AN_DEC, AN_CEN, AN_OFF), the 10-entry segment table, SEG_OFF, and default parameter values.
REQ-030 Counter width SHALL be $clog2 of max(CICLOS_DIGITO, CICLOS_BLANCO, 2).
REQ-031 One sub-module, decodificador_bcd_7seg (4-bit in, 7-bit out, per REQ-018), SHALL be instantiated once.

Verification (CICLOS_DIGITO=4, CICLOS_BLANCO=2, frame=18 cycles)
REQ-032 Reset held 3 cycles -> anodos 111, segmentos 0000000, valor_listo 1, fin_trama 0; first frame shows 0 on all three digits.
REQ-033 Load 12'h123 (supr 0) in cycle 1 after reset -> fin_trama at cycle 17; next frame: 110/1111001 for 4 cycles, 101/1101101, 011/0110000, each preceded by 2 cycles of 111/0000000.
REQ-034 Offer 12'h456 then 12'h789 back-to-back -> 456 accepted and valor_listo drops; 789 stalls until the edge after the fin_trama that activates 456, then is accepted; 456 displays for one full frame.
REQ-035 12'h007 with supr 1 -> decenas and centenas phases 111/0000000, unidades 110/1110000; 12'h000 with supr 1 -> only unidades shows 1111110.
REQ-036 12'h1A5 -> decenas phase anodos 101, segmentos 0000000, period still 18.
REQ-037 Reset pulsed during decenas MOSTRAR with a value pending -> next cycle 111/0000000, valor_listo 1, subsequent frame shows 000.

Source files
------------

// File: rtl/controlador_barrido_display_pkg.sv
// controlador_barrido_display_pkg: shared types, anode codes and segment table for the display scanner
package controlador_barrido_display_pkg;
  typedef enum logic {BLANCO, MOSTRAR} estado_t;
  localparam int DEF_CICLOS_DIGITO = 32768;
  localparam int DEF_CICLOS_BLANCO = 1024;
  localparam logic [2:0] AN_UNI = 3'b110;
  localparam logic [2:0] AN_DEC = 3'b101;
  localparam logic [2:0] AN_CEN = 3'b011;
  localparam logic [2:0] AN_OFF = 3'b111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  // entry n holds the abcdefg pattern of digit n
  localparam logic [9:0][6:0] SEG_TABLA = {
    7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011,
    7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };
endpackage

// File: rtl/decodificador_bcd_7seg.sv
// decodificador_bcd_7seg: BCD digit to active-high abcdefg segments, codes above 9 go dark
module decodificador_bcd_7seg
  import controlador_barrido_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb seg = (bcd > 4'd9) ? SEG_OFF : SEG_TABLA[bcd];
endmodule

// File: rtl/controlador_barrido_display.sv
// controlador_barrido_display: 3-digit multiplexed 7-segment scanner with frame-synchronous value update
module controlador_barrido_display
  import controlador_barrido_display_pkg::*;
#(
  parameter int CICLOS_DIGITO = DEF_CICLOS_DIGITO,
  parameter int CICLOS_BLANCO = DEF_CICLOS_BLANCO
)
(
  input  logic        reloj,
  input  logic        reset,
  input  logic        valor_valido,
  output logic        valor_listo,
  input  logic [11:0] valor_bcd,
  input  logic        supr_ceros,
  output logic [6:0]  segmentos_out,
  output logic [2:0]  anodos_out,
  output logic        fin_trama
);
  localparam int MAXDB = CICLOS_DIGITO > CICLOS_BLANCO ? CICLOS_DIGITO : CICLOS_BLANCO;
  localparam int CW = $clog2(MAXDB > 2 ? MAXDB : 2);
  localparam logic [CW-1:0] ULT_D = CW'(CICLOS_DIGITO - 1);
  localparam logic [CW-1:0] ULT_B = CW'(CICLOS_BLANCO > 0 ? CICLOS_BLANCO - 1 : 0);
  localparam estado_t INICIO = CICLOS_BLANCO == 0 ? MOSTRAR : BLANCO;
  estado_t       estado;
  logic [1:0]    indice;
  logic [CW-1:0] cnt;
  logic          pendiente, hold_supr, act_supr;
  logic [11:0]   hold_bcd, act_bcd;
  logic          fin_blanco, fin_mostrar, apagado;
  logic [3:0]    digito;
  logic [2:0]    an_sel;
  logic [6:0]    seg_dec;
  always_comb begin
    fin_blanco  = estado == BLANCO && cnt == ULT_B;
    fin_mostrar = estado == MOSTRAR && cnt == ULT_D;
    fin_trama   = fin_mostrar && indice == 2'd2;
    valor_listo = ~pendiente;
    digito      = indice == 2'd2 ? act_bcd[11:8] : indice == 2'd1 ? act_bcd[7:4] : act_bcd[3:0];
    an_sel      = indice == 2'd2 ? AN_CEN : indice == 2'd1 ? AN_DEC : AN_UNI;
    // leading-zero suppression only ever darkens centenas and decenas
    apagado     = estado == BLANCO || (act_supr && ((indice == 2'd2 && act_bcd[11:8] == 4'd0) ||
                                                    (indice == 2'd1 && act_bcd[11:4] == 8'd0)));
    anodos_out    = apagado ? AN_OFF : an_sel;
    segmentos_out = apagado ? SEG_OFF : seg_dec;
  end
  decodificador_bcd_7seg u_dec (.bcd(digito), .seg(seg_dec));
  always_ff @(posedge reloj) begin
    if (reset) begin
      estado    <= INICIO;
      indice    <= 2'd0;
      cnt       <= '0;
      pendiente <= 1'b0;
      hold_bcd  <= 12'h000;
      hold_supr <= 1'b0;
      act_bcd   <= 12'h000;
      act_supr  <= 1'b0;
    end else begin
      if (fin_blanco) begin
        estado <= MOSTRAR;
        cnt    <= '0;
      end else if (fin_mostrar) begin
        estado <= INICIO;
        cnt    <= '0;
        indice <= indice == 2'd2 ? 2'd0 : indice + 2'd1;
      end else
        cnt <= cnt + 1'b1;
      // the active value only changes at a frame boundary
      if (fin_trama && pendiente) begin
        act_bcd   <= hold_bcd;
        act_supr  <= hold_supr;
        pendiente <= 1'b0;
      end else if (valor_valido && !pendiente) begin
        hold_bcd  <= valor_bcd;
        hold_supr <= supr_ceros;
        pendiente <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_controlador_barrido_display.sv
// tb_controlador_barrido_display: directed table-driven checks of the display scanner
module tb_controlador_barrido_display;
  logic        reloj = 1'b0;
  logic        reset, valor_valido, valor_listo, supr_ceros, fin_trama;
  logic [11:0] valor_bcd;
  logic [6:0]  segmentos_out;
  logic [2:0]  anodos_out;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [11:0]     valor;
    logic            supr;
    logic [2:0][2:0] an;
    logic [2:0][6:0] seg;
  } rec_t;
  rec_t vec [7];
  localparam logic [2:0][2:0] AN_CERO  = {3'b011, 3'b101, 3'b110};
  localparam logic [2:0][6:0] SEG_CERO = {7'b1111110, 7'b1111110, 7'b1111110};
  controlador_barrido_display #(.CICLOS_DIGITO(4), .CICLOS_BLANCO(2)) dut (
    .reloj(reloj), .reset(reset), .valor_valido(valor_valido), .valor_listo(valor_listo),
    .valor_bcd(valor_bcd), .supr_ceros(supr_ceros), .segmentos_out(segmentos_out),
    .anodos_out(anodos_out), .fin_trama(fin_trama)
  );
  always #5 reloj = ~reloj;
  task automatic step();
    @(posedge reloj);
    #1;
  endtask
  task automatic check(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nombre, act, exp);
    end
  endtask
  task automatic check_idle(input string nombre);
    check({nombre, " anodos"}, 32'(anodos_out), 32'h7);
    check({nombre, " segmentos"}, 32'(segmentos_out), 32'h0);
    check({nombre, " listo"}, 32'(valor_listo), 32'h1);
    check({nombre, " fin"}, 32'(fin_trama), 32'h0);
  endtask
  // current sample is frame cycle 'desde'; leaves the bench sampling cycle 17
  task automatic check_frame(input int desde, input logic [2:0][2:0] an, input logic [2:0][6:0] seg, input string nombre);
    for (int c = desde; c < 18; c++) begin
      int p = c / 6;
      int w = c % 6;
      logic [2:0] ea = w < 2 ? 3'b111 : an[p];
      logic [6:0] es = w < 2 ? 7'b0 : seg[p];
      check($sformatf("%s c%0d anodos", nombre, c), 32'(anodos_out), 32'(ea));
      check($sformatf("%s c%0d segmentos", nombre, c), 32'(segmentos_out), 32'(es));
      check($sformatf("%s c%0d fin_trama", nombre, c), 32'(fin_trama), 32'(c == 17));
      if (c < 17) step();
    end
  endtask
  task automatic wait_fin(input string nombre);
    int n = 0;
    while (!fin_trama && n < 40) begin
      step();
      n++;
    end
    check({nombre, " fin_trama seen"}, 32'(fin_trama), 32'h1);
  endtask
  initial begin
    vec[0] = '{12'h123, 1'b0, {3'b011, 3'b101, 3'b110}, {7'b0110000, 7'b1101101, 7'b1111001}};
    vec[1] = '{12'h007, 1'b1, {3'b111, 3'b111, 3'b110}, {7'b0000000, 7'b0000000, 7'b1110000}};
    vec[2] = '{12'h000, 1'b1, {3'b111, 3'b111, 3'b110}, {7'b0000000, 7'b0000000, 7'b1111110}};
    vec[3] = '{12'h1A5, 1'b0, {3'b011, 3'b101, 3'b110}, {7'b0110000, 7'b0000000, 7'b1011011}};
    vec[4] = '{12'h050, 1'b1, {3'b111, 3'b101, 3'b110}, {7'b0000000, 7'b1011011, 7'b1111110}};
    vec[5] = '{12'h908, 1'b1, {3'b011, 3'b101, 3'b110}, {7'b1111011, 7'b1111110, 7'b1111111}};
    vec[6] = '{12'h046, 1'b0, {3'b011, 3'b101, 3'b110}, {7'b1111110, 7'b0110011, 7'b1011111}};
    reset = 1'b1;
    valor_valido = 1'b0;
    valor_bcd = 12'h000;
    supr_ceros = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle($sformatf("reset%0d", i));
    end
    reset = 1'b0;
    check_frame(0, AN_CERO, SEG_CERO, "power-up 000");
    for (int i = 0; i < 7; i++) begin
      valor_bcd = vec[i].valor;
      supr_ceros = vec[i].supr;
      valor_valido = 1'b1;
      step();
      valor_valido = 1'b0;
      check($sformatf("vec%0d listo after load", i), 32'(valor_listo), 32'h0);
      wait_fin($sformatf("vec%0d", i));
      step();
      check_frame(0, vec[i].an, vec[i].seg, $sformatf("vec%0d %03h", i, vec[i].valor));
    end
    begin
      logic prev_fin = 1'b0;
      int n = 0;
      valor_bcd = 12'h456;
      supr_ceros = 1'b0;
      valor_valido = 1'b1;
      step();
      check("456 accepted listo", 32'(valor_listo), 32'h0);
      valor_bcd = 12'h789;
      while (!valor_listo && n < 40) begin
        prev_fin = fin_trama;
        step();
        n++;
      end
      check("789 stall ends", 32'(valor_listo), 32'h1);
      check("789 released at frame end", 32'(prev_fin), 32'h1);
      step();
      valor_valido = 1'b0;
      check("789 accepted listo", 32'(valor_listo), 32'h0);
      check_frame(1, {3'b011, 3'b101, 3'b110}, {7'b0110011, 7'b1011011, 7'b1011111}, "456 frame");
      step();
      check_frame(0, {3'b011, 3'b101, 3'b110}, {7'b1110000, 7'b1111111, 7'b1111011}, "789 frame");
    end
    step();
    valor_bcd = 12'h321;
    supr_ceros = 1'b0;
    valor_valido = 1'b1;
    step();
    valor_valido = 1'b0;
    check("321 pending listo", 32'(valor_listo), 32'h0);
    repeat (8) step();
    check("mid decenas anodos", 32'(anodos_out), 32'h5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("mid reset");
    check_frame(0, AN_CERO, SEG_CERO, "after reset 000");
    step();
    check_frame(0, AN_CERO, SEG_CERO, "pending discarded 000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
